// File: rtl/mem_cycle_pkg.sv
// rtl/mem_cycle_pkg.sv - shared state encoding and default sizes for the memory cycle controller
package mem_cycle_pkg;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 8;
   localparam int DEF_WAIT_CYC = 1;
   localparam int DEF_BLEN_W   = 4;
   localparam int WCNT_W       = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRIVE,
      ST_STROBE,
      ST_RECOVER
   } state_t;

endpackage

// File: rtl/mem_cycle_ctrl_if.sv
// rtl/mem_cycle_ctrl_if.sv - request side and memory bus signals of the memory cycle controller
// master: requester/memory side, slave: the controller.
interface mem_cycle_ctrl_if import mem_cycle_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BLEN_W = DEF_BLEN_W
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr_in;
   logic [DATA_W-1:0] wdata;
   logic [BLEN_W-1:0] burst_len;
   logic [DATA_W-1:0] mem_din;
   logic              latch;
   logic              DE;
   logic              nWE;
   logic              nOE;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_dout;
   logic              writing;
   logic              reading;
   logic              rdata_valid;
   logic              done;
   logic [DATA_W-1:0] rdata;

   modport master (
      output read, write, addr_in, wdata, burst_len, mem_din,
      input  latch, DE, nWE, nOE, mem_addr, mem_dout,
      input  writing, reading, rdata_valid, done, rdata
   );

   modport slave (
      input  read, write, addr_in, wdata, burst_len, mem_din,
      output latch, DE, nWE, nOE, mem_addr, mem_dout,
      output writing, reading, rdata_valid, done, rdata
   );
endinterface

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - strobe wait-state down-counter with zero flag
module mem_wait_cnt import mem_cycle_pkg::*; #(
   parameter int WIDTH = WCNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);
   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - WIDTH'(1);
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/mem_cycle_ctrl.sv
// rtl/mem_cycle_ctrl.sv - SETUP/DRIVE/STROBE/RECOVER memory cycle sequencer with registered outputs
// Optional burst addressing enabled by defining MEM_CYCLE_BURST_EN.
module mem_cycle_ctrl import mem_cycle_pkg::*; #(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int WAIT_CYC = DEF_WAIT_CYC,
   parameter int BLEN_W   = DEF_BLEN_W
) (
   input logic             clk,
   input logic             reset,
   mem_cycle_ctrl_if.slave bus
);
   localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_CYC - 1);

   state_t            state_q, state_n;
   logic              last_q, last_n;
   logic              wr_n, rd_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] dout_n, rdata_n;
   logic              latch_n, de_n, nwe_n, noe_n, rv_n, done_n;
   logic              cnt_load, cnt_en, cnt_zero;
`ifdef MEM_CYCLE_BURST_EN
   logic [BLEN_W-1:0] beats_q, beats_n;
`endif

   mem_wait_cnt #(.WIDTH(WCNT_W)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (WAIT_LOAD),
      .en       (cnt_en),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_n  = state_q;
      last_n   = last_q;
      wr_n     = bus.writing;
      rd_n     = bus.reading;
      addr_n   = bus.mem_addr;
      dout_n   = bus.mem_dout;
      rdata_n  = bus.rdata;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
`ifdef MEM_CYCLE_BURST_EN
      beats_n  = beats_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.read ^ bus.write) begin
               state_n = ST_SETUP;
               wr_n    = bus.write;
               rd_n    = bus.read;
               addr_n  = bus.addr_in;
`ifdef MEM_CYCLE_BURST_EN
               beats_n = bus.burst_len;
`endif
            end
         end
         ST_SETUP: begin
            state_n = ST_DRIVE;
            if (bus.writing)
               dout_n = bus.wdata;
         end
         ST_DRIVE: begin
            state_n  = ST_STROBE;
            cnt_load = 1'b1;
         end
         ST_STROBE: begin
            if (cnt_zero) begin
               state_n = ST_RECOVER;
               if (bus.reading)
                  rdata_n = bus.mem_din;
               // The end-of-transaction decision is taken here so done can be registered for RECOVER.
`ifdef MEM_CYCLE_BURST_EN
               last_n = (beats_q == '0);
`else
               last_n = bus.writing ? !(bus.write && !bus.read) : !(bus.read && !bus.write);
`endif
            end else begin
               cnt_en = 1'b1;
            end
         end
         ST_RECOVER: begin
            if (last_q) begin
               state_n = ST_IDLE;
               wr_n    = 1'b0;
               rd_n    = 1'b0;
            end else begin
               state_n = ST_SETUP;
`ifdef MEM_CYCLE_BURST_EN
               addr_n  = bus.mem_addr + ADDR_W'(1);
               beats_n = beats_q - BLEN_W'(1);
`else
               addr_n  = bus.addr_in;
`endif
            end
         end
         default: state_n = ST_IDLE;
      endcase

      latch_n = (state_n == ST_SETUP);
      de_n    = wr_n && ((state_n == ST_DRIVE) || (state_n == ST_STROBE));
      nwe_n   = !(wr_n && (state_n == ST_STROBE));
      noe_n   = !(rd_n && (state_n == ST_STROBE));
      rv_n    = rd_n && (state_n == ST_RECOVER);
      done_n  = (state_n == ST_RECOVER) && last_n;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         last_q          <= 1'b0;
         bus.latch       <= 1'b0;
         bus.DE          <= 1'b0;
         bus.nWE         <= 1'b1;
         bus.nOE         <= 1'b1;
         bus.writing     <= 1'b0;
         bus.reading     <= 1'b0;
         bus.rdata_valid <= 1'b0;
         bus.done        <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_dout    <= '0;
         bus.rdata       <= '0;
`ifdef MEM_CYCLE_BURST_EN
         beats_q         <= '0;
`endif
      end else begin
         state_q         <= state_n;
         last_q          <= last_n;
         bus.latch       <= latch_n;
         bus.DE          <= de_n;
         bus.nWE         <= nwe_n;
         bus.nOE         <= noe_n;
         bus.writing     <= wr_n;
         bus.reading     <= rd_n;
         bus.rdata_valid <= rv_n;
         bus.done        <= done_n;
         bus.mem_addr    <= addr_n;
         bus.mem_dout    <= dout_n;
         bus.rdata       <= rdata_n;
`ifdef MEM_CYCLE_BURST_EN
         beats_q         <= beats_n;
`endif
      end
   end
endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// tb/tb_mem_cycle_ctrl.sv - directed vector bench for mem_cycle_ctrl (WAIT_CYC=1 and WAIT_CYC=3 instances)
module tb_mem_cycle_ctrl;
   // flag order: {latch, DE, nWE, nOE, writing, reading, rdata_valid, done}
   localparam logic [7:0] F_IDLE   = 8'b0011_0000;
   localparam logic [7:0] W_SETUP  = 8'b1011_1000;
   localparam logic [7:0] W_DRIVE  = 8'b0111_1000;
   localparam logic [7:0] W_STROBE = 8'b0101_1000;
   localparam logic [7:0] W_REC    = 8'b0011_1000;
   localparam logic [7:0] W_DONE   = 8'b0011_1001;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mem_cycle_ctrl_if #(.ADDR_W(16), .DATA_W(8), .BLEN_W(4)) bus1 ();
   mem_cycle_ctrl_if #(.ADDR_W(16), .DATA_W(8), .BLEN_W(4)) bus3 ();

   mem_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYC(1), .BLEN_W(4)) u1 (
      .clk(clk), .reset(reset), .bus(bus1));
   mem_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_CYC(3), .BLEN_W(4)) u3 (
      .clk(clk), .reset(reset), .bus(bus3));

   typedef struct {
      logic        rd;
      logic        wr;
      logic [3:0]  blen;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  eflags;
      logic [15:0] eaddr;
      logic [7:0]  edout;
   } vec_t;

   vec_t vecs[$];
   int checks = 0;
   int failures = 0;

   function automatic void add(input logic rd, input logic wr, input logic [3:0] blen,
                               input logic [15:0] addr, input logic [7:0] wdata,
                               input logic [7:0] eflags, input logic [15:0] eaddr,
                               input logic [7:0] edout);
      vec_t v;
      v.rd = rd; v.wr = wr; v.blen = blen; v.addr = addr; v.wdata = wdata;
      v.eflags = eflags; v.eaddr = eaddr; v.edout = edout;
      vecs.push_back(v);
   endfunction

   function automatic logic [7:0] flags1();
      return {bus1.latch, bus1.DE, bus1.nWE, bus1.nOE, bus1.writing, bus1.reading,
              bus1.rdata_valid, bus1.done};
   endfunction

   function automatic logic [7:0] flags3();
      return {bus3.latch, bus3.DE, bus3.nWE, bus3.nOE, bus3.writing, bus3.reading,
              bus3.rdata_valid, bus3.done};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int noe_low, nwe_low, rv_cnt, done_cnt, busy, overlap;
      logic [7:0] rdata_seen;

      // single write, WAIT_CYC=1
      add(0, 1, 0, 16'h0012, 8'hA5, W_SETUP,  16'h0012, 8'h00);
      add(0, 0, 0, 16'h0012, 8'hA5, W_DRIVE,  16'h0012, 8'hA5);
      add(0, 0, 0, 16'h0012, 8'hA5, W_STROBE, 16'h0012, 8'hA5);
      add(0, 0, 0, 16'h0012, 8'hA5, W_DONE,   16'h0012, 8'hA5);
      add(0, 0, 0, 16'h0012, 8'hA5, F_IDLE,   16'h0012, 8'hA5);
      // conflicting requests hold IDLE
      for (int i = 0; i < 10; i++)
         add(1, 1, 0, 16'h0777, 8'hEE, F_IDLE, 16'h0012, 8'hA5);
`ifdef MEM_CYCLE_BURST_EN
      add(0, 1, 3, 16'hFFFE, 8'h40, W_SETUP,  16'hFFFE, 8'hA5);
      add(0, 0, 3, 16'hFFFE, 8'h40, W_DRIVE,  16'hFFFE, 8'h40);
      add(0, 0, 3, 16'hFFFE, 8'h40, W_STROBE, 16'hFFFE, 8'h40);
      add(0, 0, 3, 16'hFFFE, 8'h40, W_REC,    16'hFFFE, 8'h40);
      add(0, 0, 3, 16'hFFFE, 8'h41, W_SETUP,  16'hFFFF, 8'h40);
      add(0, 0, 3, 16'hFFFE, 8'h41, W_DRIVE,  16'hFFFF, 8'h41);
      add(1, 0, 3, 16'hFFFE, 8'h41, W_STROBE, 16'hFFFF, 8'h41);
      add(1, 0, 3, 16'hFFFE, 8'h41, W_REC,    16'hFFFF, 8'h41);
      add(0, 0, 3, 16'hFFFE, 8'h42, W_SETUP,  16'h0000, 8'h41);
      add(0, 0, 3, 16'hFFFE, 8'h42, W_DRIVE,  16'h0000, 8'h42);
      add(0, 0, 3, 16'hFFFE, 8'h42, W_STROBE, 16'h0000, 8'h42);
      add(0, 0, 3, 16'hFFFE, 8'h42, W_REC,    16'h0000, 8'h42);
      add(0, 0, 3, 16'hFFFE, 8'h43, W_SETUP,  16'h0001, 8'h42);
      add(0, 0, 3, 16'hFFFE, 8'h43, W_DRIVE,  16'h0001, 8'h43);
      add(0, 0, 3, 16'hFFFE, 8'h43, W_STROBE, 16'h0001, 8'h43);
      add(0, 0, 3, 16'hFFFE, 8'h43, W_DONE,   16'h0001, 8'h43);
      add(0, 0, 3, 16'hFFFE, 8'h43, F_IDLE,   16'h0001, 8'h43);
`else
      // write held for three beats, address reloaded per beat
      add(0, 1, 5, 16'h0100, 8'h11, W_SETUP,  16'h0100, 8'hA5);
      add(0, 1, 5, 16'h0100, 8'h11, W_DRIVE,  16'h0100, 8'h11);
      add(0, 1, 5, 16'h0100, 8'h11, W_STROBE, 16'h0100, 8'h11);
      add(0, 1, 5, 16'h0100, 8'h11, W_REC,    16'h0100, 8'h11);
      add(0, 1, 5, 16'h0101, 8'h22, W_SETUP,  16'h0101, 8'h11);
      add(0, 1, 5, 16'h0101, 8'h22, W_DRIVE,  16'h0101, 8'h22);
      add(0, 1, 5, 16'h0101, 8'h22, W_STROBE, 16'h0101, 8'h22);
      add(0, 1, 5, 16'h0101, 8'h22, W_REC,    16'h0101, 8'h22);
      add(0, 1, 5, 16'h0102, 8'h33, W_SETUP,  16'h0102, 8'h22);
      add(0, 1, 5, 16'h0102, 8'h33, W_DRIVE,  16'h0102, 8'h33);
      add(0, 0, 5, 16'h0102, 8'h33, W_STROBE, 16'h0102, 8'h33);
      add(0, 0, 5, 16'h0102, 8'h33, W_DONE,   16'h0102, 8'h33);
      add(0, 0, 5, 16'h0102, 8'h33, F_IDLE,   16'h0102, 8'h33);
      add(0, 0, 5, 16'h0102, 8'h33, F_IDLE,   16'h0102, 8'h33);
`endif

      bus1.read = 0; bus1.write = 0; bus1.addr_in = '0; bus1.wdata = '0;
      bus1.burst_len = '0; bus1.mem_din = '0;
      bus3.read = 0; bus3.write = 0; bus3.addr_in = '0; bus3.wdata = '0;
      bus3.burst_len = '0; bus3.mem_din = '0;

      reset = 1'b1;
      repeat (3) tick();
      chk("reset_u1", {flags1(), bus1.mem_addr, bus1.mem_dout}, {F_IDLE, 16'h0000, 8'h00});
      chk("reset_u1_rdata", {24'h0, bus1.rdata}, 32'h0);
      chk("reset_u3", {flags3(), bus3.mem_addr, bus3.mem_dout}, {F_IDLE, 16'h0000, 8'h00});
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         bus1.read = vecs[i].rd;
         bus1.write = vecs[i].wr;
         bus1.burst_len = vecs[i].blen;
         bus1.addr_in = vecs[i].addr;
         bus1.wdata = vecs[i].wdata;
         tick();
         chk($sformatf("vec%0d", i), {flags1(), bus1.mem_addr, bus1.mem_dout},
             {vecs[i].eflags, vecs[i].eaddr, vecs[i].edout});
      end

      // read, WAIT_CYC=3; mem_din only becomes 0x3C during the last strobe cycle
      bus3.read = 1; bus3.addr_in = 16'h0040; bus3.mem_din = 8'h5A;
      noe_low = 0; nwe_low = 0; rv_cnt = 0; done_cnt = 0; busy = 0; overlap = 0;
      rdata_seen = 8'h00;
      tick();
      bus3.read = 0;
      for (int c = 0; c < 20; c++) begin
         if (bus3.reading) busy++;
         if (!bus3.nOE) noe_low++;
         if (!bus3.nWE) nwe_low++;
         if (!bus3.nOE && !bus3.nWE) overlap++;
         if (bus3.rdata_valid) begin rv_cnt++; rdata_seen = bus3.rdata; end
         if (bus3.done) done_cnt++;
         bus3.mem_din = (noe_low == 3) ? 8'h3C : ((noe_low > 3) ? 8'hFF : 8'h5A);
         tick();
      end
      chk("rd_noe_low_cycles", noe_low, 3);
      chk("rd_nwe_low_cycles", nwe_low, 0);
      chk("rd_strobe_overlap", overlap, 0);
      chk("rd_busy_cycles", busy, 6);
      chk("rd_valid_pulses", rv_cnt, 1);
      chk("rd_rdata_at_valid", {24'h0, rdata_seen}, 32'h3C);
      chk("rd_done_pulses", done_cnt, 1);
      chk("rd_rdata_hold", {24'h0, bus3.rdata}, 32'h3C);
      chk("rd_idle_after", {24'h0, flags3()}, {24'h0, F_IDLE});

      // reset during the second strobe cycle of a write
      bus3.write = 1; bus3.addr_in = 16'h0033; bus3.wdata = 8'h77;
      tick();
      bus3.write = 0;
      tick();
      tick();
      tick();
      chk("rst_pre_strobe2", {24'h0, flags3()}, {24'h0, W_STROBE});
      reset = 1'b1;
      tick();
      chk("rst_abort", {flags3(), bus3.mem_addr, bus3.mem_dout}, {F_IDLE, 16'h0000, 8'h00});
      reset = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (bus3.done || !bus3.nWE) done_cnt++;
      end
      chk("rst_no_done_after", done_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_cycle_ctrl.md
MEM_CYCLE_CTRL -- requirements
Module: mem_cycle_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16: width of the memory address.
REQ-002 Parameter DATA_W, default 8: width of the memory data bus.
REQ-003 Parameter WAIT_CYC, default 1, legal range 1..15: number of cycles the strobe (nWE or nOE) is held low per beat.
REQ-004 Parameter BLEN_W, default 4: width of burst_len.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Ports read and write, input, 1 each: level request lines.
REQ-008 Port addr_in, input, ADDR_W: start address, sampled when leaving IDLE.
REQ-009 Port wdata, input, DATA_W: write data, sampled on entry to each DRIVE of a write beat.
REQ-010 Port burst_len, input, BLEN_W: beats minus one, sampled when leaving IDLE.
REQ-011 Port mem_din, input, DATA_W: data returned by memory.
REQ-012 Ports latch, DE, nWE, nOE, output, 1 each: address latch, data-drive enable, active-low write strobe, active-low output-enable strobe.
REQ-013 Ports mem_addr (ADDR_W) and mem_dout (DATA_W), output: address and write data to memory.
REQ-014 Ports writing, reading, rdata_valid, done, output, 1 each; rdata, output, DATA_W.

Function
REQ-015 States: IDLE, SETUP, DRIVE, STROBE, RECOVER; all outputs are registered and take the listed values during the cycle the FSM occupies each state.
REQ-016 IDLE: if exactly one of read/write is 1, go to SETUP and set writing or reading accordingly; if both or neither are 1, stay in IDLE.
REQ-017 SETUP (1 cycle): latch=1; on entry from IDLE, mem_addr is loaded from addr_in.
REQ-018 DRIVE (1 cycle): latch=0; for a write, DE=1 and mem_dout=wdata; for a read, DE=0.
REQ-019 STROBE (WAIT_CYC cycles): nWE=0 for a write, nOE=0 for a read; for a write, DE stays 1.
REQ-020 RECOVER (1 cycle): nWE=nOE=1 and DE=0; for a read, rdata holds the mem_din value sampled on the last STROBE edge, and rdata_valid=1 for exactly this cycle.
REQ-021 Beat latency is 3+WAIT_CYC cycles; there are no idle cycles between beats of one transaction.
REQ-022 nWE and nOE are never low in the same cycle, and neither is low outside STROBE.
REQ-023 Transaction end: in the final RECOVER, done=1 for one cycle; the FSM goes to IDLE and writing/reading clear on the same edge.
REQ-024 The direction is fixed for a whole transaction; request changes inside it affect only the continue/end decision in RECOVER.

Reset
REQ-025 When reset=1 at a rising edge, the block enters IDLE with latch=0, DE=0, nWE=1, nOE=1, writing=0, reading=0, rdata_valid=0, done=0, mem_addr=0, mem_dout=0, rdata=0.
REQ-026 Reset in any state, including mid-STROBE, aborts the beat with the reset values on that edge; done is not pulsed and no write completion is implied.

Configuration
REQ-027 Macro MEM_CYCLE_BURST_EN defined: a transaction has burst_len+1 beats; in each non-final RECOVER, mem_addr increments by 1 (wrapping at 2^ADDR_W-1 to 0) and the FSM goes to SETUP; the request level is ignored until the final beat.
REQ-028 MEM_CYCLE_BURST_EN undefined: burst_len is ignored; in RECOVER, if the same request is still the only one active, the FSM goes to SETUP and reloads mem_addr from addr_in; otherwise the transaction ends per REQ-023.

Structure
REQ-029 Package mem_cycle_pkg holds the state enumeration and default parameter constants.
REQ-030 The wait-state down-counter is sub-module mem_wait_cnt: load WAIT_CYC-1, assert zero flag; it is instantiated once.

Verification
REQ-031 WAIT_CYC=1, write=1 for 1 cycle, addr_in=0x0012, wdata=0xA5 -> latch, DE, nWE-low, RECOVER in 4 cycles; mem_addr=0x0012, mem_dout=0xA5; done pulses once.
REQ-032 WAIT_CYC=3, read with mem_din=0x3C -> nOE low exactly 3 cycles; rdata=0x3C with rdata_valid high for 1 cycle.
REQ-033 BURST_EN, write, burst_len=3, addr_in=0xFFFE -> 4 beats at 0xFFFE, 0xFFFF, 0x0000, 0x0001, done after the 4th beat only.
REQ-034 read=write=1 in IDLE -> the FSM stays in IDLE for 10 cycles with all strobes inactive.
REQ-035 reset asserted during the 2nd STROBE cycle of a write -> next edge nWE=1, DE=0, writing=0, IDLE; no done.
REQ-036 Burst disabled, write held high 3 beats then dropped -> 3 nWE pulses, back-to-back beats, done on the 3rd RECOVER.
